mips_inst_encoder: RTL
======================

# mips_inst_encoder

Encodes MIPS32 R/I/J-format instructions from discrete fields into 32-bit words and buffers them, in program order, in an 8-entry instruction FIFO. It is the producer end of the instruction-word stream: the words it emits are the ones our instruction classifier and counter block decodes. It optionally keeps per-format counts of encoded instructions.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `AW`, 3: pointer width; equals log2(`DEPTH`).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_fmt` in 2: format. 00=R, 01=I, 10=J, 11=illegal.
- `req_op` in 6: opcode, used for I and J.
- `req_rs`, `req_rt`, `req_rd`, `req_shamt` in 5 each: register and shift fields.
- `req_funct` in 6: R-format function field.
- `req_imm` in 16: I-format immediate.
- `req_target` in 26: J-format target.
- `out_valid` out 1: FIFO head is valid.
- `out_ready` in 1: consumer takes the head word.
- `out_data` out 32: encoded word at the FIFO head.
- `err` out 1: one-cycle pulse when a request is rejected.
- `level` out AW+1: number of occupied entries.
- `r_count`, `i_count`, `j_count` out 4 each: encoded-instruction counts.

## Operation
- A request is accepted when `req_valid && req_ready`.
- `req_ready` = `level != DEPTH`. It is driven from registered state only, with no combinational path from `req_valid`.
- Encoding rules:
  - R: {6'b000000, rs, rt, rd, shamt, funct}. `req_op` is ignored.
  - I: {op, rs, rt, imm}. Legal only if op is not 6'h00, 6'h02 or 6'h03.
  - J: {op, target}. Legal only if op is 6'h02 or 6'h03.
- Illegal requests are fmt=11, I with op 00/02/03, or J with any other op.
  - They are accepted (consumed) but not written to the FIFO.
  - `err` pulses high for one cycle.
  - Counters do not change.
- Legal requests write to `mem[wr_ptr]`, then `wr_ptr` increments modulo `DEPTH`.
- Pop occurs when `out_valid && out_ready`; `rd_ptr` then increments modulo `DEPTH`.
- `out_valid` = `level != 0`. `out_data` = `mem[rd_ptr]`, combinational read of registered storage.
- `out_data` is don't-care while `out_valid` is low.
- Level update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged, and both pointers advance.
- Full: `req_ready`=0, so no push can occur. A pop in that cycle frees one entry, which becomes usable the following cycle.
- Empty: no pop occurs even if `out_ready`=1. There is no bypass.
- Counters increment on each legal accepted request of their format and wrap modulo 16 (15→0).
- Reset clears: `wr_ptr`, `rd_ptr`, `level`=0, `out_valid`=0, `req_ready`=1, `err`=0, all counters 0.
  - Memory contents are not cleared.
  - Reset mid-stream discards all buffered words.
  - A request presented during the reset cycle is not accepted.

## Timing
- Latency: a word accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N, so the consumer can pop it at edge N+1.
- `err` is high for exactly the one cycle following the edge at which the illegal request was accepted.
- Counters and `level` update at the accepting edge.
- Throughput: one request and one pop per cycle. Sustained full-rate streaming holds `level` constant.

## Configuration
- `MIPS_ENC_STATS_EN` defined: `r_count`, `i_count` and `j_count` are live as specified above.
- Not defined: counter registers are not built, the three outputs are tied to 4'h0, and all other behaviour is identical.

## Test plan
- I-format: fmt=01, op=6'h08, rs=0, rt=4, imm=16'h3456 → `out_data`=32'h20043456 one cycle later; `i_count`=1.
- R-format: fmt=00, rs=5, rt=4, rd=6, shamt=0, funct=6'h20 → 32'h00A43020; `r_count`=1. Repeat with op=6'h3F → same word.
- J-format: fmt=10, op=6'h02, target=26'h0123456 → 32'h08123456. Then op=6'h08 with fmt=10 → `err` pulses one cycle, `level` unchanged, `j_count` unchanged.
- Fill and stream:
  - Push 9 legal requests with `out_ready`=0 → `req_ready` drops after 8 accepts and `level`=8.
  - Assert `out_ready` → 8 words drain in push order, including wrap-around.
  - Simultaneous push and pop at level 4 → level stays 4.
- Counter wrap: 17 R requests → `r_count`=1 (with `MIPS_ENC_STATS_EN`), or 0 without the macro.
- Reset at level 5 → next cycle `level`=0, `out_valid`=0, `req_ready`=1, counters 0. A new push then emits correctly.

Source files
------------

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder: packs MIPS32 R/I/J fields into 32-bit words and queues
// them in program order in a DEPTH-entry FIFO with a combinational head read.
// Optional per-format counters are built only when MIPS_ENC_STATS_EN is defined.
module mips_inst_encoder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_fmt,
  input  logic [5:0]    req_op,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_shamt,
  input  logic [5:0]    req_funct,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          err,
  output logic [AW:0]   level,
  output logic [3:0]    r_count,
  output logic [3:0]    i_count,
  output logic [3:0]    j_count
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          err_q, err_d;
  logic [31:0]   word;
  logic          legal;
  logic          accept;
  logic          push;
  logic          pop;

  // Status flags come from the registered level only, never from req_valid.
  assign req_ready = (level_q != LVL_FULL);
  assign out_valid = (level_q != '0);
  assign out_data  = mem[rd_ptr_q];
  assign level     = level_q;
  assign err       = err_q;

  assign accept = req_valid && req_ready && !reset;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready && !reset;

  // Field packing and legality check for the presented request.
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (req_fmt)
      2'b00: begin
        word  = {6'b000000, req_rs, req_rt, req_rd, req_shamt, req_funct};
        legal = 1'b1;
      end
      2'b01: begin
        word  = {req_op, req_rs, req_rt, req_imm};
        legal = !((req_op == 6'h00) || (req_op == 6'h02) || (req_op == 6'h03));
      end
      2'b10: begin
        word  = {req_op, req_target};
        legal = (req_op == 6'h02) || (req_op == 6'h03);
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Next-state for pointers, occupancy and the reject pulse.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = accept && !legal;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state registers; buffered words are discarded by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
    end
  end

  // Storage is left uninitialised; only occupancy tracks what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= word;
  end

`ifdef MIPS_ENC_STATS_EN
  logic [3:0] r_cnt_q, r_cnt_d;
  logic [3:0] i_cnt_q, i_cnt_d;
  logic [3:0] j_cnt_q, j_cnt_d;

  // Per-format counts of legal accepted requests, wrapping at 16.
  always_comb begin
    r_cnt_d = r_cnt_q;
    i_cnt_d = i_cnt_q;
    j_cnt_d = j_cnt_q;
    if (push) begin
      case (req_fmt)
        2'b00:   r_cnt_d = r_cnt_q + 4'd1;
        2'b01:   i_cnt_d = i_cnt_q + 4'd1;
        2'b10:   j_cnt_d = j_cnt_q + 4'd1;
        default: ;
      endcase
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_q <= '0;
      i_cnt_q <= '0;
      j_cnt_q <= '0;
    end else begin
      r_cnt_q <= r_cnt_d;
      i_cnt_q <= i_cnt_d;
      j_cnt_q <= j_cnt_d;
    end
  end

  assign r_count = r_cnt_q;
  assign i_count = i_cnt_q;
  assign j_count = j_cnt_q;
`else
  assign r_count = 4'h0;
  assign i_count = 4'h0;
  assign j_count = 4'h0;
`endif

endmodule
